d_reg_sequencer: RTL and testbench

- Control FSM for the online-division digit store (the generate_d_reg d_plus/d_minus RAM pair).
- Runs the online-delay prologue, then gates one quotient digit per accepted cycle into the shift word.
- Drives the per-word left-align shift, the word-boundary refresh, the write/read word addresses and the digit counter.
- Signals completion once the requested digit count has been stored.

---
 rtl/d_reg_sequencer.sv | 137 +++++++++++++
 tb/tb_d_reg_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/d_reg_sequencer.sv
// Control FSM for the online-division digit store: runs the online-delay prologue,
// then strobes one quotient digit per accepted cycle into the left-aligned shift word.
module d_reg_sequencer #(
  parameter int UNROLLING    = 64,
  parameter int LOG_UNROLL   = 6,
  parameter int ONLINE_DELAY = 3,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  input  logic [10:0]           num_digits,
  input  logic                  digit_valid,
  output logic                  enable,
  output logic                  refresh,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [10:0]           counter,
  output logic [10:0]           shift_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int DCW = (ONLINE_DELAY > 1) ? $clog2(ONLINE_DELAY) : 1;
  localparam logic [DCW-1:0] DLY_LAST = DCW'(ONLINE_DELAY - 1);

  logic [1:0]            state_q,   state_d;
  logic [10:0]           len_q,     len_d;
  logic [10:0]           k_q,       k_d;
  logic [DCW-1:0]        dly_q,     dly_d;
  logic                  enable_q,  enable_d;
  logic                  refresh_q, refresh_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [10:0]           counter_q, counter_d;
  logic [10:0]           shift_q,   shift_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;

  logic                  take_digit;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    k_d       = k_q;
    dly_d     = dly_q;
    enable_d  = 1'b0;
    refresh_d = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = wr_addr_q;
    counter_d = counter_q;
    shift_d   = shift_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_DELAY;
          len_d     = num_digits;
          dly_d     = '0;
          k_d       = '0;
          wr_addr_d = '0;
          rd_addr_d = '0;
          counter_d = '0;
          shift_d   = '0;
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_LAST) state_d = (len_q == 11'd0) ? S_FIN : S_RUN;
        else                   dly_d   = dly_q + 1'b1;
      end
      S_RUN: begin
        // k reaches the count on the last enable cycle; the next cycle is the done pulse
        if (k_q == len_q) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase

    // A digit is taken on the edge that opens a RUN cycle; k < count is implied by S_RUN
    take_digit = (state_d == S_RUN) && digit_valid;
    if (take_digit) begin
      enable_d  = 1'b1;
      counter_d = k_q;
      shift_d   = 11'(UNROLLING - 1) - 11'(k_q[LOG_UNROLL-1:0]);
      wr_addr_d = ADDR_WIDTH'(k_q >> LOG_UNROLL);
      refresh_d = (k_q[LOG_UNROLL-1:0] == '0) && (k_q != 11'd0);
      k_d       = k_q + 11'd1;
    end

    busy_d = (state_d == S_DELAY) || (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      k_q       <= '0;
      dly_q     <= '0;
      enable_q  <= 1'b0;
      refresh_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      counter_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      k_q       <= k_d;
      dly_q     <= dly_d;
      enable_q  <= enable_d;
      refresh_q <= refresh_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      counter_q <= counter_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign enable    = enable_q;
  assign refresh   = refresh_q;
  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_addr_q;
  assign counter   = counter_q;
  assign shift_cnt = shift_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_d_reg_sequencer.sv
// Randomized bench for d_reg_sequencer against a cycle-level reference of the digit-store rules.
module tb_d_reg_sequencer;
  localparam int UNR = 64;
  localparam int OD  = 3;
  localparam int AW  = 7;

  logic          clk = 1'b0;
  logic          asyn_reset, start, digit_valid;
  logic [10:0]   num_digits;
  logic          enable, refresh, busy, done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [10:0]   counter, shift_cnt;

  int n_vec = 0;
  int n_bad = 0;
  // expected held values of the address / index outputs
  int e_wr = 0, e_rd = 0, e_cnt = 0, e_sh = 0;

  always #5 clk = ~clk;

  d_reg_sequencer dut (
    .clk(clk), .asyn_reset(asyn_reset), .start(start), .num_digits(num_digits),
    .digit_valid(digit_valid), .enable(enable), .refresh(refresh),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .counter(counter), .shift_cnt(shift_cnt),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input bit en, input bit rf, input bit by, input bit dn);
    chk("enable",    32'(enable),    32'(en));
    chk("refresh",   32'(refresh),   32'(rf));
    chk("busy",      32'(busy),      32'(by));
    chk("done",      32'(done),      32'(dn));
    chk("wr_addr",   32'(wr_addr),   e_wr);
    chk("rd_addr",   32'(rd_addr),   e_rd);
    chk("counter",   32'(counter),   e_cnt);
    chk("shift_cnt", 32'(shift_cnt), e_sh);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return logic'(cyc % 2 == 0);
      default: return logic'($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // One division: n digits, digit_valid pattern by mode; optional reset when counter hits
  // abort_at, optional stray start (count 3) applied before the edge after cycle poke_cyc.
  task automatic run_div(input int n, input int mode, input int abort_at, input int poke_cyc);
    int  k = 0;
    bit  fin = 0, aborted = 0, do_abort = 0;
    bit  dv_now, en, rf;
    e_wr = 0; e_cnt = 0; e_sh = 0;
    start = 1'b1; num_digits = 11'(n); digit_valid = pick(mode, 0);
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      dv_now = digit_valid;
      tick();
      if (do_abort) begin
        asyn_reset = 1'b0;
        e_wr = 0; e_rd = 0; e_cnt = 0; e_sh = 0;
        check_all(0, 0, 0, 0);
        aborted = 1;
        break;
      end
      e_rd = e_wr;
      en = 0; rf = 0;
      if (cyc <= OD) begin
        check_all(0, 0, 1, 0);
      end else if (k < n) begin
        if (dv_now) begin
          en    = 1;
          e_cnt = k;
          e_sh  = UNR - 1 - (k % UNR);
          e_wr  = (k / UNR) % (1 << AW);
          rf    = (k % UNR == 0) && (k != 0);
          k++;
        end
        check_all(en, rf, 1, 0);
        if (en && e_cnt == abort_at) begin
          asyn_reset = 1'b1;
          do_abort   = 1;
        end
      end else begin
        check_all(0, 0, 0, 1);
        fin = 1;
      end
      digit_valid = pick(mode, cyc);
      start       = (cyc == poke_cyc);
      num_digits  = start ? 11'd3 : 11'(n);
      if (fin) break;
    end
    start = 1'b0;
    if (!fin && !aborted) chk("timeout", 32'd0, 32'd1);
    if (fin) begin
      digit_valid = pick(2, 0);
      tick();
      e_rd = e_wr;
      check_all(0, 0, 0, 0);
    end
  endtask

  initial begin
    asyn_reset = 1'b1; start = 1'b0; digit_valid = 1'b0; num_digits = '0;
    repeat (3) tick();
    check_all(0, 0, 0, 0);
    asyn_reset = 1'b0;
    digit_valid = 1'b1;
    tick();
    check_all(0, 0, 0, 0);

    run_div(5,   0, -1, -1);
    run_div(130, 0, -1, -1);
    run_div(10,  1, -1, -1);
    run_div(0,   2, -1, -1);
    run_div(100, 0, 40, -1);
    run_div(7,   0, -1, -1);
    run_div(20,  0, -1, 10);

    // start coincident with reset is lost
    asyn_reset = 1'b1; start = 1'b1; num_digits = 11'd9;
    tick();
    e_wr = 0; e_rd = 0; e_cnt = 0; e_sh = 0;
    check_all(0, 0, 0, 0);
    asyn_reset = 1'b0; start = 1'b0;
    tick();
    check_all(0, 0, 0, 0);

    for (int r = 0; r < 6; r++) run_div($urandom_range(1, 200), 2, -1, -1);
    run_div(2047, 2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
